song_scorer: RTL and testbench
==============================

Name: song_scorer

Overview:
- Judging end of the study-mode goal-note stream.
- Steps through a song's goal notes, fetching each from the song ROM interface by index.
- Compares each user hit (from the key/hit front end) against the current goal note and timing window, and emits a per-note judgement.
- Keeps running score and combo for display logic; runs alongside the goal-note LED path.

Parameters:
- CNT_BITS, 7, song index width; matches the song ROM index width.
- OCT_BITS, 3, octave field width.
- NOTE_BITS, 3, note field width; value 0 = rest.
- LEN_BITS, 3, length field width, in units.
- UNIT_TICKS, 25000000, clk cycles per length unit.
- PERFECT_TICKS, 12500000, hits at timer <= this judge PERFECT.
- TIMER_BITS, 28, beat timer width; must hold (2^LEN_BITS)*UNIT_TICKS.
- SCORE_BITS, 10, score/combo width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  study/score mode enable; level.
- track  in  CNT_BITS  index of last note of the selected song.
- goal_octave  in  OCT_BITS  ROM data at index cnt; combinational, valid same cycle.
- goal_note  in  NOTE_BITS  ROM data at index cnt; combinational, valid same cycle.
- goal_length  in  LEN_BITS  ROM data at index cnt; combinational, valid same cycle.
- hit_valid  in  1  one-cycle pulse per user key hit; already edge-converted.
- hit_octave  in  OCT_BITS  octave of the hit, sampled with hit_valid.
- hit_note  in  NOTE_BITS  note of the hit, sampled with hit_valid.
- cnt  out  CNT_BITS  current goal index to the song ROM.
- result_valid  out  1  one-cycle pulse per judged note.
- result  out  2  00 MISS, 01 GOOD, 10 PERFECT; held until the next judgement.
- score  out  SCORE_BITS  accumulated score.
- combo  out  SCORE_BITS  current consecutive non-MISS count.
- max_combo  out  SCORE_BITS  best combo this run.
- done  out  1  high in DONE state.

Behaviour:
- Reset: state IDLE; cnt, timer, score, combo, max_combo, result = 0; result_valid = 0; done = 0.
- FSM states: IDLE, WAIT, JUDGE, DONE. All state and outputs are registered.
- IDLE: on en=1, clear cnt, timer, score, combo, max_combo, result -> WAIT next cycle. Score values persist in IDLE until then.
- WAIT:
  - timer increments every cycle.
  - Deadline = max(goal_length,1) * UNIT_TICKS; the multiply is computed at TIMER_BITS width.
  - Note goal (goal_note != 0):
    - hit_valid with hit_octave==goal_octave and hit_note==goal_note: PERFECT if timer <= PERFECT_TICKS, else GOOD.
    - hit_valid with a mismatch: MISS.
    - timer == deadline-1 with no hit: MISS.
    - Any of these -> JUDGE.
  - Rest goal (goal_note == 0): hits are ignored. At the deadline, advance directly with no judgement, no result_valid, and combo unchanged.
  - hit_valid and deadline in the same cycle: the hit is judged; the timeout is discarded.
  - Only the first hit per note is judged. Later hits for that index are unreachable because the state has left WAIT.
- JUDGE (exactly 1 cycle):
  - result_valid = 1; result register updated.
  - score += 2 (PERFECT), 1 (GOOD), 0 (MISS); saturates at all-ones.
  - combo: +1 (saturating) on non-MISS, 0 on MISS.
  - max_combo = max(max_combo, new combo).
  - Then if cnt == track -> DONE, else cnt+1, timer=0 -> WAIT.
- Latency: hit_valid in cycle N -> result_valid in cycle N+1 -> new cnt visible in cycle N+2.
- DONE: done=1 and cnt holds; stays until en=0 -> IDLE.
- en=0 in any state: next cycle IDLE, timer=0, result_valid=0. Score, combo and max_combo are retained.
- track=0: single-note song; its judgement goes to DONE.
- cnt never wraps; the index range is bounded by track.
- rst mid-run: immediate return to reset values regardless of state.

Decomposition:
- Shared constants package: result encodings (MISS/GOOD/PERFECT) and the field widths (OCT/NOTE/LEN/CNT bits), so the song ROM, LED path and scorer agree.
- One natural sub-module, score_accum: saturating score/combo/max_combo update, driven by result_valid and result.

Test Plan (bench params: UNIT_TICKS=10, PERFECT_TICKS=4, track=2, notes {oct4 n1 len1}, {rest len2}, {oct4 n3 len1}):
- Correct hit oct4 n1 at timer=3 -> result_valid next cycle, result=PERFECT, score=2, combo=1, cnt=1 one cycle later.
- Correct hit at timer=7 -> result=GOOD, score=1, combo=1.
- Wrong note n2 at timer=2 -> result=MISS, score=0, combo=0.
- No hit on note 0 -> MISS pulse at timer=9.
- Rest index 1: hits at timer 5 are ignored; after 20 cycles cnt=2 with no result_valid.
- Full run PERFECT, rest, GOOD -> score=3, combo=2, max_combo=2, done=1.
- Hit and deadline in the same cycle -> judged from the hit.
- Drop en mid-WAIT, then raise it -> cnt=0, score cleared, timer restarts.
- Assert rst mid-run -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/song_scorer_pkg.sv
// Shared constants for the study-mode note path: field widths, judgement
// encodings and the scorer state type, so ROM, LED path and scorer agree.
package song_scorer_pkg;

  localparam int unsigned SS_CNT_BITS   = 7;
  localparam int unsigned SS_OCT_BITS   = 3;
  localparam int unsigned SS_NOTE_BITS  = 3;
  localparam int unsigned SS_LEN_BITS   = 3;
  localparam int unsigned SS_SCORE_BITS = 10;

  typedef enum logic [1:0] {
    RES_MISS    = 2'b00,
    RES_GOOD    = 2'b01,
    RES_PERFECT = 2'b10
  } result_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_JUDGE,
    ST_DONE
  } state_e;

  // Points awarded for one judgement.
  function automatic logic [1:0] result_points(input result_e r);
    case (r)
      RES_PERFECT: result_points = 2'd2;
      RES_GOOD:    result_points = 2'd1;
      default:     result_points = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/song_scorer_if.sv
// Scorer bus: mode enable, song ROM lookup, user hit input and judgement
// outputs. slave = the scorer, master = whatever drives it.
interface song_scorer_if
  import song_scorer_pkg::*;
#(
  parameter int unsigned CNT_BITS   = SS_CNT_BITS,
  parameter int unsigned OCT_BITS   = SS_OCT_BITS,
  parameter int unsigned NOTE_BITS  = SS_NOTE_BITS,
  parameter int unsigned LEN_BITS   = SS_LEN_BITS,
  parameter int unsigned SCORE_BITS = SS_SCORE_BITS
) ();

  logic                  en;
  logic [CNT_BITS-1:0]   track;
  logic [OCT_BITS-1:0]   goal_octave;
  logic [NOTE_BITS-1:0]  goal_note;
  logic [LEN_BITS-1:0]   goal_length;
  logic                  hit_valid;
  logic [OCT_BITS-1:0]   hit_octave;
  logic [NOTE_BITS-1:0]  hit_note;
  logic [CNT_BITS-1:0]   cnt;
  logic                  result_valid;
  logic [1:0]            result;
  logic [SCORE_BITS-1:0] score;
  logic [SCORE_BITS-1:0] combo;
  logic [SCORE_BITS-1:0] max_combo;
  logic                  done;

  modport slave (
    input  en, track, goal_octave, goal_note, goal_length,
           hit_valid, hit_octave, hit_note,
    output cnt, result_valid, result, score, combo, max_combo, done
  );

  modport master (
    output en, track, goal_octave, goal_note, goal_length,
           hit_valid, hit_octave, hit_note,
    input  cnt, result_valid, result, score, combo, max_combo, done
  );

endinterface

// File: rtl/song_scorer_score_accum.sv
// Saturating score / combo / best-combo accumulator, updated once per
// judgement pulse and cleared at the start of a run.
module song_scorer_score_accum
  import song_scorer_pkg::*;
#(
  parameter int unsigned SCORE_BITS = SS_SCORE_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  result_valid,
  input  result_e               result,
  output logic [SCORE_BITS-1:0] score,
  output logic [SCORE_BITS-1:0] combo,
  output logic [SCORE_BITS-1:0] max_combo
);

  logic [SCORE_BITS:0]   score_sum;
  logic [SCORE_BITS-1:0] score_n;
  logic [SCORE_BITS-1:0] combo_n;
  logic [SCORE_BITS-1:0] max_n;

  // Next values with saturation at all-ones.
  always_comb begin
    score_sum = {1'b0, score} + (SCORE_BITS + 1)'(result_points(result));
    score_n   = score_sum[SCORE_BITS] ? '1 : score_sum[SCORE_BITS-1:0];
    if (result == RES_MISS) combo_n = '0;
    else if (&combo)        combo_n = combo;
    else                    combo_n = combo + SCORE_BITS'(1);
    max_n = (combo_n > max_combo) ? combo_n : max_combo;
  end

  // Commit on each judgement; run start wipes the tallies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score     <= '0;
      combo     <= '0;
      max_combo <= '0;
    end else if (clear) begin
      score     <= '0;
      combo     <= '0;
      max_combo <= '0;
    end else if (result_valid) begin
      score     <= score_n;
      combo     <= combo_n;
      max_combo <= max_n;
    end
  end

endmodule

// File: rtl/song_scorer.sv
// Study-mode judge: walks the song's goal notes by index, judges the first
// user hit (or a timeout) against each note and tracks score and combo.
module song_scorer
  import song_scorer_pkg::*;
#(
  parameter int unsigned CNT_BITS      = SS_CNT_BITS,
  parameter int unsigned OCT_BITS      = SS_OCT_BITS,
  parameter int unsigned NOTE_BITS     = SS_NOTE_BITS,
  parameter int unsigned LEN_BITS      = SS_LEN_BITS,
  parameter int unsigned UNIT_TICKS    = 25000000,
  parameter int unsigned PERFECT_TICKS = 12500000,
  parameter int unsigned TIMER_BITS    = 28,
  parameter int unsigned SCORE_BITS    = SS_SCORE_BITS
) (
  input  logic         clk,
  input  logic         rst,
  song_scorer_if.slave bus
);

  state_e                state;
  logic [CNT_BITS-1:0]   cnt_q;
  logic [TIMER_BITS-1:0] timer;
  result_e               result_q;
  logic                  result_valid_q;
  logic                  done_q;

  logic [OCT_BITS-1:0]   goal_oct;
  logic [NOTE_BITS-1:0]  goal_nt;
  logic [LEN_BITS-1:0]   goal_len;
  logic [LEN_BITS-1:0]   len_eff;
  logic [TIMER_BITS-1:0] deadline;
  logic                  at_deadline;
  logic                  is_rest;
  logic                  last_note;
  result_e               hit_res;
  logic                  start;

  assign goal_oct = bus.goal_octave;
  assign goal_nt  = bus.goal_note;
  assign goal_len = bus.goal_length;

  // Deadline and hit judgement for the goal note currently addressed.
  always_comb begin
    len_eff     = (goal_len == '0) ? LEN_BITS'(1) : goal_len;
    deadline    = TIMER_BITS'(len_eff) * TIMER_BITS'(UNIT_TICKS);
    at_deadline = (timer == deadline - TIMER_BITS'(1));
    is_rest     = (goal_nt == '0);
    last_note   = (cnt_q == bus.track);
    hit_res     = RES_MISS;
    if (bus.hit_octave == goal_oct && bus.hit_note == goal_nt)
      hit_res = (timer <= TIMER_BITS'(PERFECT_TICKS)) ? RES_PERFECT : RES_GOOD;
  end

  assign start = (state == ST_IDLE) && bus.en;

  // Scoring FSM; en low from any state parks it in IDLE with tallies kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      cnt_q          <= '0;
      timer          <= '0;
      result_q       <= RES_MISS;
      result_valid_q <= 1'b0;
      done_q         <= 1'b0;
    end else if (!bus.en) begin
      state          <= ST_IDLE;
      timer          <= '0;
      result_valid_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt_q    <= '0;
          timer    <= '0;
          result_q <= RES_MISS;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          timer <= timer + TIMER_BITS'(1);
          if (!is_rest) begin
            // A hit wins over a timeout landing in the same cycle.
            if (bus.hit_valid) begin
              result_q       <= hit_res;
              result_valid_q <= 1'b1;
              state          <= ST_JUDGE;
            end else if (at_deadline) begin
              result_q       <= RES_MISS;
              result_valid_q <= 1'b1;
              state          <= ST_JUDGE;
            end
          end else if (at_deadline) begin
            if (last_note) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_BITS'(1);
              timer <= '0;
            end
          end
        end
        ST_JUDGE: begin
          result_valid_q <= 1'b0;
          if (last_note) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_BITS'(1);
            timer <= '0;
            state <= ST_WAIT;
          end
        end
        default: begin
          state <= ST_DONE;
        end
      endcase
    end
  end

  song_scorer_score_accum #(
    .SCORE_BITS(SCORE_BITS)
  ) u_accum (
    .clk          (clk),
    .rst          (rst),
    .clear        (start),
    .result_valid (result_valid_q),
    .result       (result_q),
    .score        (bus.score),
    .combo        (bus.combo),
    .max_combo    (bus.max_combo)
  );

  assign bus.cnt          = cnt_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_song_scorer.sv
// Bench for song_scorer: three-note song (note, rest, note) played with
// directed and random hits, judged against a rule-level reference model.
module tb_song_scorer;

  localparam int UNIT      = 10;
  localparam int PERF      = 4;
  localparam int TRACK     = 2;
  localparam int R_MISS    = 0;
  localparam int R_GOOD    = 1;
  localparam int R_PERFECT = 2;
  localparam int SAT       = 1023;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int rom_oct  [3] = '{4, 0, 4};
  int rom_note [3] = '{1, 0, 3};
  int rom_len  [3] = '{1, 2, 1};

  int m_score, m_combo, m_max;
  int vectors = 0;
  int miscompares = 0;

  song_scorer_if bus ();

  song_scorer #(
    .UNIT_TICKS    (UNIT),
    .PERFECT_TICKS (PERF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.track = 7'(TRACK);

  // Combinational song ROM.
  always_comb begin
    bus.goal_octave = '0;
    bus.goal_note   = '0;
    bus.goal_length = '0;
    if (bus.cnt < 7'd3) begin
      bus.goal_octave = 3'(rom_oct[bus.cnt]);
      bus.goal_note   = 3'(rom_note[bus.cnt]);
      bus.goal_length = 3'(rom_len[bus.cnt]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // kind: 0 no hit, 1 correct hit, 2 wrong note, 3 wrong octave.
  function automatic int expect_judge(int kind, int t, int deadline);
    if (kind == 0 || t >= deadline) return R_MISS;
    if (kind != 1) return R_MISS;
    return (t <= PERF) ? R_PERFECT : R_GOOD;
  endfunction

  function automatic void model_clear();
    m_score = 0;
    m_combo = 0;
    m_max   = 0;
  endfunction

  function automatic void model_score(int r);
    m_score += (r == R_PERFECT) ? 2 : (r == R_GOOD) ? 1 : 0;
    if (m_score > SAT) m_score = SAT;
    if (r == R_MISS) m_combo = 0;
    else if (m_combo < SAT) m_combo++;
    if (m_combo > m_max) m_max = m_combo;
  endfunction

  // Starts at the timer=0 cycle of note idx; ends at the cycle after JUDGE.
  task automatic play_note(input int idx, input int kind, input int t);
    int d, r;
    d = ((rom_len[idx] == 0) ? 1 : rom_len[idx]) * UNIT;
    r = expect_judge(kind, t, d);
    if (kind == 0 || t >= d) begin
      repeat (d - 1) tick();
      check("pre_timeout_rv", bus.result_valid, 0);
      tick();
    end else begin
      repeat (t) tick();
      bus.hit_valid  = 1'b1;
      bus.hit_octave = (kind == 3) ? 3'(rom_oct[idx] + 1) : 3'(rom_oct[idx]);
      bus.hit_note   = (kind == 2) ? 3'(rom_note[idx] % 7 + 1) : 3'(rom_note[idx]);
      tick();
      bus.hit_valid = 1'b0;
    end
    check("judge_rv", bus.result_valid, 1);
    check("judge_result", bus.result, r);
    check("judge_cnt", bus.cnt, idx);
    model_score(r);
    tick();
    check("after_rv", bus.result_valid, 0);
    check("result_hold", bus.result, r);
    check("score", bus.score, m_score);
    check("combo", bus.combo, m_combo);
    check("max_combo", bus.max_combo, m_max);
    if (idx == TRACK) begin
      check("done", bus.done, 1);
      check("done_cnt", bus.cnt, TRACK);
    end else begin
      check("next_cnt", bus.cnt, idx + 1);
      check("not_done", bus.done, 0);
    end
  endtask

  // Rest at index 1; hit_t < 0 means no hit during the rest.
  task automatic play_rest(input int hit_t);
    for (int i = 0; i < rom_len[1] * UNIT; i++) begin
      if (i == hit_t) begin
        bus.hit_valid  = 1'b1;
        bus.hit_octave = 3'($urandom_range(0, 7));
        bus.hit_note   = 3'($urandom_range(0, 7));
      end
      tick();
      bus.hit_valid = 1'b0;
      check("rest_rv", bus.result_valid, 0);
    end
    check("rest_cnt", bus.cnt, 2);
    check("rest_combo", bus.combo, m_combo);
  endtask

  task automatic restart();
    bus.en = 1'b0;
    tick();
    bus.en = 1'b1;
    tick();
    model_clear();
    check("restart_cnt", bus.cnt, 0);
    check("restart_score", bus.score, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cnt"}, bus.cnt, 0);
    check({tag, "_rv"}, bus.result_valid, 0);
    check({tag, "_result"}, bus.result, 0);
    check({tag, "_score"}, bus.score, 0);
    check({tag, "_combo"}, bus.combo, 0);
    check({tag, "_max"}, bus.max_combo, 0);
    check({tag, "_done"}, bus.done, 0);
  endtask

  initial begin
    bus.en         = 1'b0;
    bus.hit_valid  = 1'b0;
    bus.hit_octave = '0;
    bus.hit_note   = '0;
    model_clear();

    // Reset state
    repeat (2) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check_all_zero("idle");

    // Full run: PERFECT, rest with a stray hit, GOOD
    bus.en = 1'b1;
    tick();
    check("start_cnt", bus.cnt, 0);
    play_note(0, 1, 3);
    play_rest(5);
    play_note(2, 1, 7);
    check("run_a_score", bus.score, 3);
    check("run_a_combo", bus.combo, 2);
    check("run_a_max", bus.max_combo, 2);
    repeat (3) tick();
    check("done_hold", bus.done, 1);
    check("done_cnt_hold", bus.cnt, TRACK);

    // Leave DONE: tallies kept in IDLE, cleared on restart
    bus.en = 1'b0;
    tick();
    check("idle_done", bus.done, 0);
    check("idle_score_kept", bus.score, 3);
    check("idle_max_kept", bus.max_combo, 2);
    bus.en = 1'b1;
    tick();
    model_clear();
    check("clr_score", bus.score, 0);
    check("clr_combo", bus.combo, 0);
    check("clr_max", bus.max_combo, 0);
    check("clr_cnt", bus.cnt, 0);

    // Wrong note, quiet rest, timeout MISS
    play_note(0, 2, 2);
    play_rest(-1);
    play_note(2, 0, 0);

    // Hit on the deadline cycle, then en dropped mid-WAIT
    restart();
    play_note(0, 1, 9);
    repeat (6) tick();
    bus.en = 1'b0;
    tick();
    check("drop_rv", bus.result_valid, 0);
    check("drop_score_kept", bus.score, 1);
    check("drop_done", bus.done, 0);
    bus.en = 1'b1;
    tick();
    model_clear();
    check("reen_cnt", bus.cnt, 0);
    check("reen_score", bus.score, 0);
    play_note(0, 0, 0);
    play_rest(int'($urandom_range(0, 19)));
    play_note(2, 1, 0);

    // Random runs
    for (int run = 0; run < 15; run++) begin
      restart();
      play_note(0, int'($urandom_range(0, 3)), int'($urandom_range(0, 11)));
      play_rest(int'($urandom_range(0, 25)) - 5);
      play_note(2, int'($urandom_range(0, 3)), int'($urandom_range(0, 11)));
    end

    // Asynchronous reset mid-run
    restart();
    play_note(0, 1, 2);
    check("pre_rst_score", bus.score, 2);
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    tick();
    rst = 1'b0;
    bus.en = 1'b0;
    tick();
    check_all_zero("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
